// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the MEM-stage data port: size/rw codes, FSM encoding, request payload.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int unsigned CNT_W = 4;

  // Exported so the hazard unit can decode the responder state directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Number of bytes touched by a size code; reserved maps to 1 (rejected elsewhere).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_steer.sv
// Byte-lane steering: big-endian read assembly, per-byte write enables/data, misalignment.
// Lane 3 (bits [31:24]) is the byte at the base address, lane 0 the byte at base+3.
module data_mem_responder_lane_steer
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rbytes,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c,
  output logic [3:0]  wen_c,
  output logic [31:0] wbytes_c,
  output logic        misalign_c
);

  // Select lanes by access size; reserved size yields nothing.
  always_comb begin
    rdata_c    = '0;
    wen_c      = '0;
    wbytes_c   = '0;
    misalign_c = 1'b0;
    case (size)
      SZ_BYTE: begin
        rdata_c  = {24'b0, rbytes[31:24]};
        wen_c    = 4'b1000;
        wbytes_c = {wdata[7:0], 24'b0};
      end
      SZ_HALF: begin
        rdata_c    = {16'b0, rbytes[31:16]};
        wen_c      = 4'b1100;
        wbytes_c   = {wdata[15:0], 16'b0};
        misalign_c = addr_lo[0];
      end
      SZ_WORD: begin
        rdata_c    = rbytes;
        wen_c      = 4'b1111;
        wbytes_c   = wdata;
        misalign_c = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: wait states, then one array access, then a one-cycle done.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        R,
  input  logic        req_en,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Not reset: preloaded hierarchically by the enclosing level.
  logic [7:0] Memory [DEPTH];

  state_t          state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  mem_req_t        req, req_d;
  logic [31:0]     rdata_d;
  logic            err_d, done_d, busy_d;
  logic            mem_we_c;
  logic            illegal_c;
  logic [31:0]     rbytes_c;
  logic [AW-1:0]   widx_c [4];
  logic [31:0]     steer_rdata_c;
  logic [3:0]      wen_c;
  logic [31:0]     wbytes_c;
  logic            misalign_c;

  // Gather the four bytes at base..base+3; out-of-range lanes read as zero.
  always_comb begin
    rbytes_c = '0;
    for (int k = 0; k < 4; k++) begin
      widx_c[k] = AW'(req.addr + 32'(k));
      if ((req.addr + 32'(k)) < 32'(DEPTH)) begin
        rbytes_c[8*(3-k) +: 8] = Memory[widx_c[k]];
      end
    end
  end

  data_mem_responder_lane_steer u_steer (
    .size       (req.size),
    .addr_lo    (req.addr[1:0]),
    .rbytes     (rbytes_c),
    .wdata      (req.wdata),
    .rdata_c    (steer_rdata_c),
    .wen_c      (wen_c),
    .wbytes_c   (wbytes_c),
    .misalign_c (misalign_c)
  );

  // 33-bit end-address compare so addresses near 2^32 cannot wrap into range.
  assign illegal_c = (req.size == SZ_RSVD) || misalign_c ||
                     (({1'b0, req.addr} + 33'(size_bytes(req.size)) - 33'd1) >= 33'(DEPTH));

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    req_d    = req;
    rdata_d  = rdata;
    err_d    = err;
    mem_we_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_en) begin
          req_d   = '{rw: req_rw, size: req_size, addr: req_addr, wdata: req_wdata};
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        err_d    = illegal_c;
        rdata_d  = (illegal_c || (req.rw != RW_READ)) ? 32'h0 : steer_rdata_c;
        mem_we_c = !illegal_c && (req.rw == RW_WRITE);
        state_d  = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge Clk) begin
    if (R) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
      rdata <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      req   <= req_d;
      rdata <= rdata_d;
      err   <= err_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  // Array write on the ACCESS edge; a reset on that edge suppresses it.
  always_ff @(posedge Clk) begin
    if (!R && mem_we_c) begin
      for (int k = 0; k < 4; k++) begin
        if (wen_c[3-k]) Memory[widx_c[k]] <= wbytes_c[8*(3-k) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus randomized traffic.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r, req_en, req_rw, busy, done, err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rdata;
  logic        r1, req_en1, busy1, done1, err1;
  logic [31:0] req_addr1, rdata1;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .Clk(clk), .R(r), .req_en(req_en), .req_rw(req_rw), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .Clk(clk), .R(r1), .req_en(req_en1), .req_rw(1'b0), .req_size(2'b10),
    .req_addr(req_addr1), .req_wdata(32'h0),
    .busy(busy1), .done(done1), .rdata(rdata1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] init_mem  [DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb1_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: big-endian byte array, accesses described by byte count and alignment.
  function automatic exp_t ref_access(input logic rw, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int n;
    longint unsigned a;
    logic bad;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    a = 64'(addr);
    bad = (n == 0);
    if (!bad) bad = ((a % 64'(n)) != 0) || (a + 64'(n) - 1 >= 64'(DEPTH));
    e.rdata = 32'h0;
    e.err = bad;
    e.acc = 0;
    if (!bad) begin
      for (int k = 0; k < n; k++) begin
        if (rw) model_mem[int'(a) + k] = 8'(wdata >> (8 * (n - 1 - k)));
        else    e.rdata = (e.rdata << 8) | 32'(model_mem[int'(a) + k]);
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Present a request in IDLE, record the expectation at the accepting edge, then scramble inputs.
  task automatic issue(input logic rw, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    wait_idle();
    req_en = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    e = ref_access(rw, size, addr, wdata);
    e.acc = cyc;
    sb_q.push_back(e);
    req_en = 1'b0;
    req_rw = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic check_mem_image();
    int diffs = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (dut.Memory[i] !== model_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);
  endtask

  // Monitor for the main instance: every done pops one expectation.
  exp_t mon_e;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk("rdata", rdata, mon_e.rdata);
        chk("err", 32'(err), 32'(mon_e.err));
        // done sits in cycle WAITC+2 counting the cycle after the accept edge as 1.
        chk("latency", 32'(cyc - mon_e.acc), 32'(WAITC + 1));
      end
      if (prev_done === 1'b1) chk("done_width", 32'd2, 32'd1);
    end
    prev_done = done;
  end

  // Monitor for the zero-wait instance: data plus IDLE/ACCESS/RESP period of 3 cycles.
  exp_t mon1_e;
  int last1 = -1;
  int n_done1 = 0;
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      n_done1++;
      if (sb1_q.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
      else begin
        mon1_e = sb1_q.pop_front();
        chk("rdata1", rdata1, mon1_e.rdata);
        chk("err1", 32'(err1), 32'd0);
      end
      if (last1 >= 0) chk("b2b_period", 32'(cyc - last1), 32'd3);
      last1 = cyc;
    end
  end

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    exp_t e;
    int t;
    r = 1'b1; r1 = 1'b1;
    req_en = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    req_en1 = 1'b0; req_addr1 = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      model_mem[i] = b; init_mem[i] = b;
      dut.Memory[i] = b; dut1.Memory[i] = b;
    end

    // Reset held two edges with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    req_en = 1'b0; r = 1'b0; r1 = 1'b0;
    @(negedge clk);
    chk("no_access_after_rst", 32'(busy), 32'd0);
    check_mem_image();

    // Word write then read back.
    issue(1'b1, SZ_WORD, 32'd8, 32'hDEADBEEF);
    issue(1'b0, SZ_WORD, 32'd8, 32'h0);
    wait_idle();
    chk("m8", 32'(dut.Memory[8]), 32'hDE);
    chk("m9", 32'(dut.Memory[9]), 32'hAD);
    chk("m10", 32'(dut.Memory[10]), 32'hBE);
    chk("m11", 32'(dut.Memory[11]), 32'hEF);

    // Byte merge, then word and half reads.
    issue(1'b1, SZ_BYTE, 32'd9, 32'h000000AA);
    issue(1'b0, SZ_WORD, 32'd8, 32'h0);
    issue(1'b0, SZ_HALF, 32'd10, 32'h0);
    wait_idle();
    chk("m9_merged", 32'(dut.Memory[9]), 32'hAA);

    // Illegal accesses, reads and writes.
    issue(1'b0, SZ_WORD, 32'd6, 32'h0);
    issue(1'b0, SZ_RSVD, 32'd0, 32'h0);
    issue(1'b0, SZ_WORD, 32'(DEPTH - 2), 32'h0);
    issue(1'b1, SZ_WORD, 32'(DEPTH - 2), 32'h11223344);
    issue(1'b1, SZ_HALF, 32'd5, 32'h5555);
    issue(1'b1, SZ_RSVD, 32'd4, 32'h66666666);
    issue(1'b0, SZ_BYTE, 32'hFFFF_FFFF, 32'h0);
    issue(1'b0, SZ_BYTE, 32'(DEPTH - 1), 32'h0);
    wait_idle();
    check_mem_image();

    // Write aborted by reset in WAIT: no done, array untouched.
    wait_idle();
    req_en = 1'b1; req_rw = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_en = 1'b0;
    @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    r = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("abort_mem", 32'(dut.Memory[16 + k]), 32'(model_mem[16 + k]));

    // Randomized traffic.
    repeat (80) begin
      case ($urandom_range(0, 9))
        0: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        1: a = 32'(DEPTH - 4) + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, DEPTH - 1));
      endcase
      issue(1'($urandom), 2'($urandom_range(0, 3)), a, $urandom);
    end
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    wait_idle();
    check_mem_image();

    // Zero-wait instance, req_en held high across three word reads.
    for (int k = 0; k < 3; k++) begin
      e.rdata = {init_mem[32 + 4*k], init_mem[33 + 4*k], init_mem[34 + 4*k], init_mem[35 + 4*k]};
      e.err = 1'b0;
      e.acc = 0;
      sb1_q.push_back(e);
    end
    @(negedge clk);
    req_addr1 = 32'h20;
    req_en1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      @(negedge clk);
      while (done1 !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("b2b_timeout", 32'd1, 32'd0);
      req_addr1 = req_addr1 + 32'd4;
      if (k == 2) req_en1 = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("b2b_count", 32'(n_done1), 32'd3);
    chk("b2b_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
